uart_tx_fifo_engine: RTL and testbench

Next-generation UART transmit path. It combines a parametrised synchronous TX FIFO with a serializer driven by the shared 16x baud tick (baudClk from baud_rate_generator). Unlike the single-word transmitter, it buffers DEPTH words, reports FIFO occupancy, supports a configurable oversample factor, and accepts back-to-back frames with no idle gap. It sits between the APB data-register write path and the UARTTXD pad.

---
 rtl/uart_pkg.sv | 52 +++++
 rtl/uart_tx_fifo_engine_if.sv | 17 +
 rtl/uart_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo_engine.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_fifo_engine.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the buffered UART transmit path.
//   tx_state_t  : serializer state encoding
//   WL_5..WL_8  : word_len field encodings
//   data_bits() : number of data bits selected by word_len
//   parity_bit(): parity value for the low nbits of a word
// -----------------------------------------------------------------------------
package uart_pkg;

    // Widest word the 2-bit word_len field can select.
    localparam int MAX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } tx_state_t;

    localparam logic [1:0] WL_5 = 2'b00;
    localparam logic [1:0] WL_6 = 2'b01;
    localparam logic [1:0] WL_7 = 2'b10;
    localparam logic [1:0] WL_8 = 2'b11;

    function automatic logic [3:0] data_bits(input logic [1:0] word_len);
        case (word_len)
            WL_5:    return 4'd5;
            WL_6:    return 4'd6;
            WL_7:    return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

    // Stick parity ignores the data; otherwise even parity is the plain XOR
    // of the transmitted bits and odd parity is its complement.
    function automatic logic parity_bit(input logic [MAX_W-1:0] data,
                                        input logic [3:0]       nbits,
                                        input logic             even,
                                        input logic             stick);
        logic x;
        x = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < int'(nbits)) x = x ^ data[i];
        end
        if (stick) return !even;
        return even ? x : !x;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_engine_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_engine_if
// Write handshake into the TX FIFO.
//   wr_data  : word to enqueue (master -> slave)
//   wr_valid : write request    (master -> slave)
//   wr_ready : FIFO not full    (slave -> master)
// -----------------------------------------------------------------------------
interface uart_tx_fifo_engine_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with show-ahead head word.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_push_data : enqueue request and word (ignored when full)
//   i_pop          : dequeue request (ignored when empty)
//   o_head         : word at the read pointer, valid while !o_empty
//   o_level, o_full, o_empty : occupancy
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 8,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW     = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [LW-1:0]     o_level,
    output logic              o_full,
    output logic              o_empty
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              w_push_ok;
    logic              w_pop_ok;

    // Acceptance is judged on the occupancy before the edge, so a push while
    // full is dropped even if a pop frees a slot on the same edge.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
endmodule

// File: rtl/uart_tx_fifo_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_engine
// Buffered UART transmitter: TX FIFO feeding a frame serializer paced by the
// shared oversampled baud tick.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   wr_if (slave)       : wr_data / wr_valid / wr_ready write handshake
//   i_uart_en, i_tx_en  : both required to start a new frame
//   i_word_len, i_parity_en, i_even_parity_sel, i_stick_parity_sel,
//   i_two_stop_bits     : frame format, latched when a word is popped
//   i_send_break        : forces the line low while asserted
//   i_baud_clk          : one-cycle tick, OVERSAMPLE ticks per bit
//   o_fifo_level, o_fifo_empty, o_fifo_full : FIFO occupancy
//   o_tx_busy           : frame in progress or data queued
//   o_uart_txd          : registered serial output
// -----------------------------------------------------------------------------
module uart_tx_fifo_engine #(
    parameter  int DEPTH      = 16,
    parameter  int DATA_W     = 8,
    parameter  int OVERSAMPLE = 16,
    localparam int LW         = $clog2(DEPTH + 1),
    localparam int TW         = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    uart_tx_fifo_engine_if.slave   wr_if,
    input  logic                   i_uart_en,
    input  logic                   i_tx_en,
    input  logic [1:0]             i_word_len,
    input  logic                   i_parity_en,
    input  logic                   i_even_parity_sel,
    input  logic                   i_stick_parity_sel,
    input  logic                   i_two_stop_bits,
    input  logic                   i_send_break,
    input  logic                   i_baud_clk,
    output logic [LW-1:0]          o_fifo_level,
    output logic                   o_fifo_empty,
    output logic                   o_fifo_full,
    output logic                   o_tx_busy,
    output logic                   o_uart_txd
);
    import uart_pkg::*;

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    logic [DATA_W-1:0] w_head;
    logic [MAX_W-1:0]  w_head_word;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    uart_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (wr_if.wr_valid),
        .i_push_data (wr_if.wr_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_level     (o_fifo_level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign wr_if.wr_ready = !w_full;
    assign o_fifo_full    = w_full;
    assign o_fifo_empty   = w_empty;

    // Fit the stored word to the serializer width; unused upper bits read 0.
    for (genvar gi = 0; gi < MAX_W; gi++) begin : g_head
        if (gi < DATA_W) begin : g_bit
            assign w_head_word[gi] = w_head[gi];
        end else begin : g_pad
            assign w_head_word[gi] = 1'b0;
        end
    end

    tx_state_t        r_state,    w_state_next;
    logic [TW-1:0]    r_tick,     w_tick_next;
    logic [3:0]       r_bit,      w_bit_next;
    logic [3:0]       r_nbits,    w_nbits_next;
    logic [MAX_W-1:0] r_shift,    w_shift_next;
    logic             r_par_en,   w_par_en_next;
    logic             r_par_val,  w_par_val_next;
    logic             r_two_stop, w_two_stop_next;
    logic             r_txd,      w_txd_next;
    logic             w_bit_end;
    logic             w_can_start;
    logic             w_load;
    logic             w_line;

    assign w_bit_end   = i_baud_clk && (r_tick == TICK_LAST);
    assign w_can_start = !w_empty && i_uart_en && i_tx_en;

    always_comb begin
        w_state_next    = r_state;
        w_tick_next     = r_tick;
        w_bit_next      = r_bit;
        w_nbits_next    = r_nbits;
        w_shift_next    = r_shift;
        w_par_en_next   = r_par_en;
        w_par_val_next  = r_par_val;
        w_two_stop_next = r_two_stop;
        w_load          = 1'b0;
        w_pop           = 1'b0;
        w_line          = 1'b1;

        if (r_state != ST_IDLE && i_baud_clk)
            w_tick_next = w_bit_end ? '0 : r_tick + 1'b1;

        case (r_state)
            ST_IDLE:  w_load = w_can_start;
            ST_START: if (w_bit_end) w_state_next = ST_DATA;
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == r_nbits - 4'd1) begin
                        w_state_next = r_par_en ? ST_PARITY : ST_STOP1;
                    end else begin
                        w_shift_next = r_shift >> 1;
                        w_bit_next   = r_bit + 4'd1;
                    end
                end
            end
            ST_PARITY: if (w_bit_end) w_state_next = ST_STOP1;
            ST_STOP1: begin
                if (w_bit_end) begin
                    if (r_two_stop)       w_state_next = ST_STOP2;
                    else if (w_can_start) w_load = 1'b1;
                    else                  w_state_next = ST_IDLE;
                end
            end
            ST_STOP2: begin
                if (w_bit_end) begin
                    if (w_can_start) w_load = 1'b1;
                    else             w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Popping the head and latching the frame format happen on the same
        // edge, so format changes only apply from the next frame onward.
        if (w_load) begin
            w_pop           = 1'b1;
            w_state_next    = ST_START;
            w_tick_next     = '0;
            w_bit_next      = '0;
            w_shift_next    = w_head_word;
            w_nbits_next    = data_bits(i_word_len);
            w_par_en_next   = i_parity_en;
            w_par_val_next  = parity_bit(w_head_word, data_bits(i_word_len),
                                         i_even_parity_sel, i_stick_parity_sel);
            w_two_stop_next = i_two_stop_bits;
        end

        // The line register follows the state being entered, so the start
        // bit appears in the cycle right after the pop.
        case (w_state_next)
            ST_START:  w_line = 1'b0;
            ST_DATA:   w_line = w_shift_next[0];
            ST_PARITY: w_line = w_par_val_next;
            default:   w_line = 1'b1;
        endcase
        w_txd_next = i_send_break ? 1'b0 : w_line;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_tick     <= '0;
            r_bit      <= '0;
            r_nbits    <= 4'd8;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_val  <= 1'b0;
            r_two_stop <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_tick     <= w_tick_next;
            r_bit      <= w_bit_next;
            r_nbits    <= w_nbits_next;
            r_shift    <= w_shift_next;
            r_par_en   <= w_par_en_next;
            r_par_val  <= w_par_val_next;
            r_two_stop <= w_two_stop_next;
            r_txd      <= w_txd_next;
        end
    end

    assign o_uart_txd = r_txd;
    assign o_tx_busy  = (r_state != ST_IDLE) || !w_empty;
endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_engine
// Self-checking bench: expected frames are queued when words are written and
// compared sample-by-sample by a line monitor when the DUT transmits them.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_engine;

    localparam int OVS = 16;

    typedef struct {
        logic [1:0]  wl;
        logic        par;
        logic        even;
        logic        stick;
        logic        two;
        logic [7:0]  data;
        logic [15:0] bits;   // bit i = i-th transmitted bit (start first)
        int          n;
    } vec_t;

    typedef struct {
        logic [15:0] bits;
        int          n;
        logic [7:0]  data;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       uart_en = 1'b0;
    logic       tx_en = 1'b0;
    logic [1:0] word_len = 2'b11;
    logic       parity_en = 1'b0;
    logic       even_sel = 1'b0;
    logic       stick_sel = 1'b0;
    logic       two_stop = 1'b0;
    logic       send_break = 1'b0;
    logic       baud_clk = 1'b1;
    logic [4:0] fifo_level;
    logic       fifo_empty;
    logic       fifo_full;
    logic       tx_busy;
    logic       txd;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int frames_done = 0;
    logic mon_en = 1'b0;
    frame_t exp_q[$];
    int frame_start[$];
    vec_t vecs[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo_engine_if #(.DATA_W(8)) wr_if ();

    uart_tx_fifo_engine #(.DEPTH(16), .DATA_W(8), .OVERSAMPLE(OVS)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .wr_if              (wr_if),
        .i_uart_en          (uart_en),
        .i_tx_en            (tx_en),
        .i_word_len         (word_len),
        .i_parity_en        (parity_en),
        .i_even_parity_sel  (even_sel),
        .i_stick_parity_sel (stick_sel),
        .i_two_stop_bits    (two_stop),
        .i_send_break       (send_break),
        .i_baud_clk         (baud_clk),
        .o_fifo_level       (fifo_level),
        .o_fifo_empty       (fifo_empty),
        .o_fifo_full        (fifo_full),
        .o_tx_busy          (tx_busy),
        .o_uart_txd         (txd)
    );

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [7:0] d);
        @(negedge clk);
        wr_if.wr_data  = d;
        wr_if.wr_valid = 1'b1;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        $display("write %02h level_after=%0d", d, fifo_level);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(name, frames_done, target);
    endtask

    task automatic wait_start(input int s0, input string name);
        int n;
        n = 0;
        while (frame_start.size() == s0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq(name, frame_start.size(), s0 + 1);
    endtask

    // Line monitor: a start bit pops the next expected frame; every bit must
    // hold its value for all OVS samples with tx_busy high.
    initial begin : monitor
        frame_t f;
        int     mism;
        logic   aborted;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && txd === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, no frame queued", cyc);
                    while (txd === 1'b0 && mon_en) @(negedge clk);
                end else begin
                    f = exp_q.pop_front();
                    frame_start.push_back(cyc);
                    aborted = 1'b0;
                    for (int b = 0; b < f.n && !aborted; b++) begin
                        mism = 0;
                        for (int s = 0; s < OVS; s++) begin
                            if (b != 0 || s != 0) @(negedge clk);
                            if (!mon_en || !rst_n) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (txd !== f.bits[b] || tx_busy !== 1'b1) mism++;
                        end
                        if (!aborted)
                            check_eq($sformatf("frame_%02h_bit%0d_bad_samples", f.data, b), mism, 0);
                    end
                    if (!aborted) begin
                        frames_done++;
                        $display("frame %02h received at cycle %0d", f.data, frame_start[frame_start.size()-1]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int tgt;
        int s0;
        int t0;
        int mism;

        wr_if.wr_data  = 8'h00;
        wr_if.wr_valid = 1'b0;

        //            wl     par  even stick two  data   bits (stop..start)                       n
        vecs[0] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, {5'b0, 1'b1, 1'b0, 8'hAA, 1'b0}, 11}; // 8E1
        vecs[1] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80, {5'b0, 2'b11, 1'b1, 7'h00, 1'b0}, 11}; // 7O2
        vecs[2] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, {5'b0, 1'b1, 1'b0, 8'hFF, 1'b0}, 11}; // stick, even=1
        vecs[3] = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, {5'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11}; // stick, even=0
        vecs[4] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF3, {9'b0, 1'b1, 5'b10011, 1'b0}, 7};     // 5N1
        vecs[5] = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h2D, {7'b0, 1'b1, 1'b1, 6'b101101, 1'b0}, 9}; // 6O1
        vecs[6] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, {5'b0, 2'b11, 8'h3C, 1'b0}, 11};      // 8N2
        vecs[7] = '{2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFE, {6'b0, 1'b1, 1'b0, 7'h7E, 1'b0}, 10}; // 7E1

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_txd", txd, 1);
        check_eq("reset_level", fifo_level, 0);
        check_eq("reset_empty", fifo_empty, 1);
        check_eq("reset_full", fifo_full, 0);
        check_eq("reset_wr_ready", wr_if.wr_ready, 1);
        check_eq("reset_busy", tx_busy, 0);
        rst_n = 1'b1;

        // Table of single frames in assorted formats
        uart_en = 1'b1;
        tx_en   = 1'b1;
        mon_en  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            word_len  = vecs[i].wl;
            parity_en = vecs[i].par;
            even_sel  = vecs[i].even;
            stick_sel = vecs[i].stick;
            two_stop  = vecs[i].two;
            exp_q.push_back('{bits: vecs[i].bits, n: vecs[i].n, data: vecs[i].data});
            tgt = frames_done + 1;
            write_word(vecs[i].data);
            wait_frames(tgt, 300, $sformatf("vec%0d_frame_done", i));
            @(negedge clk);
            check_eq($sformatf("vec%0d_busy_after_stop", i), tx_busy, 0);
            check_eq($sformatf("vec%0d_idle_line", i), txd, 1);
        end

        // Fill while disabled, overflow, then drain back-to-back
        @(negedge clk);
        uart_en   = 1'b0;
        word_len  = 2'b11;
        parity_en = 1'b0;
        two_stop  = 1'b0;
        stick_sel = 1'b0;
        for (int k = 0; k < 16; k++) write_word(8'(k));
        @(negedge clk);
        check_eq("fill_level", fifo_level, 16);
        check_eq("fill_full", fifo_full, 1);
        check_eq("fill_wr_ready", wr_if.wr_ready, 0);
        check_eq("fill_busy_idle", tx_busy, 1);
        write_word(8'hEE);
        @(negedge clk);
        check_eq("overflow_level", fifo_level, 16);
        for (int k = 0; k < 16; k++)
            exp_q.push_back('{bits: {5'b0, 1'b1, 8'(k), 1'b0}, n: 10, data: 8'(k)});
        s0  = frame_start.size();
        tgt = frames_done + 16;
        uart_en = 1'b1;
        wait_frames(tgt, 16 * 160 + 100, "fill_frames_done");
        if (frame_start.size() >= s0 + 16) begin
            for (int k = 1; k < 16; k++)
                check_eq($sformatf("b2b_spacing_%0d", k),
                         frame_start[s0+k] - frame_start[s0+k-1], 160);
        end
        @(negedge clk);
        check_eq("drain_empty", fifo_empty, 1);
        check_eq("drain_busy", tx_busy, 0);

        // Break mid-DATA of 8'h55, followed by queued 8'h02
        @(negedge clk);
        uart_en = 1'b0;
        write_word(8'h55);
        write_word(8'h02);
        exp_q.push_back('{bits: {6'b0, 1'b1, 8'h55, 1'b0}, n: 10, data: 8'h55});
        exp_q.push_back('{bits: {6'b0, 1'b1, 8'h02, 1'b0}, n: 10, data: 8'h02});
        s0 = frame_start.size();
        uart_en = 1'b1;
        wait_start(s0, "break_frame_start");
        if (frame_start.size() > s0) begin
            t0 = frame_start[s0];
            while (cyc < t0 + 40) @(negedge clk);
            mon_en     = 1'b0;
            send_break = 1'b1;
            @(negedge clk);
            check_eq("break_next_edge", txd, 0);
            mism = 0;
            repeat (20) begin
                @(negedge clk);
                if (txd !== 1'b0) mism++;
            end
            check_eq("break_held_bad_samples", mism, 0);
            check_eq("break_fifo_level", fifo_level, 1);
            check_eq("break_busy", tx_busy, 1);
            while (cyc < t0 + 82) @(negedge clk);
            send_break = 1'b0;
            @(negedge clk);
            check_eq("break_release_line", txd, 1);   // data bit 4 of 8'h55
            while (cyc < t0 + 150) @(negedge clk);
            mon_en = 1'b1;
            tgt = frames_done + 1;
            wait_frames(tgt, 300, "after_break_frame_done");
            if (frame_start.size() > s0 + 1)
                check_eq("after_break_b2b", frame_start[s0+1] - t0, 160);
        end

        // Asynchronous reset mid-frame
        @(negedge clk);
        exp_q.push_back('{bits: {6'b0, 1'b1, 8'h55, 1'b0}, n: 10, data: 8'h55});
        s0 = frame_start.size();
        write_word(8'h55);
        write_word(8'h33);
        wait_start(s0, "reset_frame_start");
        if (frame_start.size() > s0) begin
            t0 = frame_start[s0];
            while (cyc < t0 + 40) @(negedge clk);
            mon_en = 1'b0;
            check_eq("pre_reset_line", txd, 0);
            check_eq("pre_reset_level", fifo_level, 1);
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            check_eq("async_reset_txd", txd, 1);
            check_eq("async_reset_level", fifo_level, 0);
            check_eq("async_reset_busy", tx_busy, 0);
            check_eq("async_reset_empty", fifo_empty, 1);
            exp_q.delete();
            repeat (2) @(negedge clk);
            rst_n  = 1'b1;
            mon_en = 1'b1;
            exp_q.push_back('{bits: {6'b0, 1'b1, 8'h55, 1'b0}, n: 10, data: 8'h55});
            tgt = frames_done + 1;
            write_word(8'h55);
            wait_frames(tgt, 300, "post_reset_frame_done");
            @(negedge clk);
            check_eq("post_reset_busy", tx_busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
